message_scroller: RTL and testbench

- Upstream feeder for the four-digit LED driver. Holds a fixed 16-character hex message and presents a 4-character window on digit3..digit0, where digit3 is the leftmost.
- Advances the window by one character every SCROLL_CYCLES clocks.
- Two raw push-buttons control it: one pauses/resumes scrolling, the other single-steps the window while paused. Both buttons are synchronised and debounced internally.
- The LED driver consumes digit3..digit0 directly and does the 7-segment decode and multiplexing.

---
 rtl/msg_pkg.sv | 34 +++
 rtl/button_debouncer.sv | 51 +++++
 rtl/message_scroller.sv | 99 +++++++++
 tb/tb_message_scroller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared message constants and window helpers for the message scroller.
// The message ROM holds one hex character per slot; index 0 is shown first.
package msg_pkg;

  localparam int unsigned MSG_LEN = 16;
  localparam int unsigned PTR_W   = $clog2(MSG_LEN);
  localparam int unsigned DIGIT_W = 4;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t MSG_ROM [MSG_LEN] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
    4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
  };

  localparam logic [PTR_W:0] MSG_LEN_X = (PTR_W+1)'(MSG_LEN);

  // Modular add that also works when MSG_LEN is not a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t off);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + {1'b0, off};
    if (sum >= MSG_LEN_X) begin
      ptr_add = PTR_W'(sum - MSG_LEN_X);
    end else begin
      ptr_add = sum[PTR_W-1:0];
    end
  endfunction

  function automatic digit_t msg_char(input ptr_t p, input ptr_t off);
    msg_char = MSG_ROM[ptr_add(p, off)];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-flop synchroniser, stability-count debouncer
// and a registered one-cycle pulse on each debounced press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/message_scroller.sv
// Scrolls a 4-character window across the message ROM, with debounced
// pause/resume and single-step buttons. All outputs are registered.
module message_scroller
  import msg_pkg::*;
#(
  parameter int unsigned SCROLL_CYCLES   = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_pause,
  input  logic               btn_step,
  output logic [DIGIT_W-1:0] digit3,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit0,
  output logic               scroll_tick,
  output logic               paused
);

  localparam int unsigned      SC_W    = $clog2(SCROLL_CYCLES);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SCROLL_CYCLES - 1);

  logic            pause_evt_s, step_evt_s;
  logic            terminal_s, advance_s;
  logic [SC_W-1:0] cnt_q, cnt_d;
  ptr_t            ptr_q, ptr_d;
  logic            paused_q, paused_d;
  logic            tick_q, tick_d;
  digit_t          dig3_q, dig2_q, dig1_q, dig0_q;
  digit_t          dig3_d, dig2_d, dig1_d, dig0_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk   (clk),
    .rst_n (reset),
    .btn_i (btn_pause),
    .rise_o(pause_evt_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .rst_n (reset),
    .btn_i (btn_step),
    .rise_o(step_evt_s)
  );

  // Scroll and step decisions use the pre-edge pause state, so a pause
  // request never suppresses a scroll landing in the same cycle.
  always_comb begin
    terminal_s = ~paused_q & (cnt_q == SC_LAST);
    advance_s  = terminal_s | (paused_q & step_evt_s);
    paused_d   = paused_q ^ pause_evt_s;
    tick_d     = advance_s;
    if (paused_q || terminal_s || pause_evt_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + SC_W'(1);
    end
    if (advance_s) begin
      ptr_d = ptr_add(ptr_q, PTR_W'(1));
    end else begin
      ptr_d = ptr_q;
    end
    dig3_d = msg_char(ptr_d, PTR_W'(0));
    dig2_d = msg_char(ptr_d, PTR_W'(1));
    dig1_d = msg_char(ptr_d, PTR_W'(2));
    dig0_d = msg_char(ptr_d, PTR_W'(3));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
      dig3_q   <= msg_char(PTR_W'(0), PTR_W'(0));
      dig2_q   <= msg_char(PTR_W'(0), PTR_W'(1));
      dig1_q   <= msg_char(PTR_W'(0), PTR_W'(2));
      dig0_q   <= msg_char(PTR_W'(0), PTR_W'(3));
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      paused_q <= paused_d;
      tick_q   <= tick_d;
      dig3_q   <= dig3_d;
      dig2_q   <= dig2_d;
      dig1_q   <= dig1_d;
      dig0_q   <= dig0_d;
    end
  end

  assign digit3      = dig3_q;
  assign digit2      = dig2_q;
  assign digit1      = dig1_q;
  assign digit0      = dig0_q;
  assign scroll_tick = tick_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller (SCROLL_CYCLES=8, DEBOUNCE_CYCLES=4).
module tb_message_scroller;

  logic       clk;
  logic       reset;
  logic       btn_pause;
  logic       btn_step;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       scroll_tick;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_ptr  = 0;
  logic prev_tick = 1'b0;

  typedef struct {
    int          wait_n;
    logic        bp;
    logic        bs;
    logic [15:0] dig;
    logic        pz;
    logic        tk;
  } vec_t;

  vec_t tbl[18];

  message_scroller #(.SCROLL_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pause  (btn_pause),
    .btn_step   (btn_step),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .scroll_tick(scroll_tick),
    .paused     (paused)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] win(input int p);
    win = {4'(p % 16), 4'((p + 1) % 16), 4'((p + 2) % 16), 4'((p + 3) % 16)};
  endfunction

  function automatic logic [15:0] dig_now();
    dig_now = {digit3, digit2, digit1, digit0};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) begin
      exp_ptr = (exp_ptr + 1) % 16;
      exp_q.push_back(exp_ptr);
    end
  endtask

  // Advance n clock edges; every tick is matched against the scoreboard.
  task automatic cyc(input int n);
    int p;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (scroll_tick) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_tick: got tick with digits %h, expected no tick", dig_now());
        end else begin
          p = exp_q.pop_front();
          check("sb_window", dig_now(), win(p));
        end
        check("tick_single", 16'(prev_tick), 16'(0));
      end
      prev_tick = scroll_tick;
    end
  endtask

  task automatic chk_state(input string name, input logic [15:0] d, input logic pz, input logic tk);
    check({name, "_digits"}, dig_now(), d);
    check({name, "_paused"}, 16'(paused), 16'(pz));
    check({name, "_tick"}, 16'(scroll_tick), 16'(tk));
  endtask

  initial begin
    //           wait  bp    bs    digits    pz    tk
    tbl[0]  = '{7,   1'b0, 1'b0, 16'h0123, 1'b0, 1'b0};
    tbl[1]  = '{1,   1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    tbl[2]  = '{1,   1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[3]  = '{103, 1'b0, 1'b0, 16'hEF01, 1'b0, 1'b1};
    tbl[4]  = '{8,   1'b0, 1'b0, 16'hF012, 1'b0, 1'b1};
    tbl[5]  = '{8,   1'b0, 1'b0, 16'h0123, 1'b0, 1'b1};
    tbl[6]  = '{6,   1'b1, 1'b0, 16'h0123, 1'b0, 1'b0};
    tbl[7]  = '{1,   1'b1, 1'b0, 16'h0123, 1'b1, 1'b0};
    tbl[8]  = '{3,   1'b1, 1'b0, 16'h0123, 1'b1, 1'b0};
    tbl[9]  = '{47,  1'b0, 1'b0, 16'h0123, 1'b1, 1'b0};
    tbl[10] = '{6,   1'b0, 1'b1, 16'h0123, 1'b1, 1'b0};
    tbl[11] = '{1,   1'b0, 1'b0, 16'h1234, 1'b1, 1'b1};
    tbl[12] = '{1,   1'b0, 1'b0, 16'h1234, 1'b1, 1'b0};
    tbl[13] = '{7,   1'b0, 1'b0, 16'h1234, 1'b1, 1'b0};
    tbl[14] = '{6,   1'b1, 1'b0, 16'h1234, 1'b1, 1'b0};
    tbl[15] = '{1,   1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[16] = '{7,   1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[17] = '{1,   1'b0, 1'b0, 16'h2345, 1'b0, 1'b1};

    btn_pause = 1'b0;
    btn_step  = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    cyc(3);
    chk_state("reset", 16'h0123, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 16 free-running scrolls, the step and the resume scroll
    push_n(18);
    for (int i = 0; i < 18; i++) begin
      btn_pause = tbl[i].bp;
      btn_step  = tbl[i].bs;
      cyc(tbl[i].wait_n);
      chk_state($sformatf("vec%0d", i), tbl[i].dig, tbl[i].pz, tbl[i].tk);
    end

    // Bouncing pause button: no toggle, scrolling continues
    push_n(4);
    for (int k = 0; k < 5; k++) begin
      btn_pause = 1'b1; cyc(2);
      btn_pause = 1'b0; cyc(2);
    end
    cyc(12);
    chk_state("bounce", 16'h6789, 1'b0, 1'b1);

    // Stable press toggles exactly once; release does not toggle
    btn_pause = 1'b1; cyc(6);
    check("hold_before", 16'(paused), 16'(0));
    btn_pause = 1'b0; cyc(1);
    check("hold_after", 16'(paused), 16'(1));
    cyc(16);
    chk_state("hold_single", 16'h6789, 1'b1, 1'b0);
    btn_pause = 1'b1; cyc(6);
    btn_pause = 1'b0; cyc(1);
    check("resume2", 16'(paused), 16'(0));

    // Step while running is ignored; cadence stays every 8
    push_n(2);
    cyc(2);
    btn_step = 1'b1; cyc(6);
    chk_state("run_step_a", 16'h789A, 1'b0, 1'b1);
    btn_step = 1'b0; cyc(1);
    chk_state("run_step_b", 16'h789A, 1'b0, 1'b0);
    cyc(7);
    chk_state("run_step_c", 16'h89AB, 1'b0, 1'b1);

    // Pause at ptr=9, then async reset between edges, mid-debounce
    push_n(1);
    cyc(6);
    btn_pause = 1'b1; cyc(6);
    btn_pause = 1'b0; cyc(1);
    chk_state("pre_reset", 16'h9ABC, 1'b1, 1'b0);
    btn_step = 1'b1;
    cyc(4);
    #4 reset = 1'b0;
    #2;
    chk_state("async_reset", 16'h0123, 1'b0, 1'b0);
    check("sb_empty_reset", 16'(exp_q.size()), 16'(0));
    btn_step = 1'b0;
    exp_ptr  = 0;
    cyc(2);
    @(negedge clk);
    reset = 1'b1;
    push_n(1);
    cyc(7);
    chk_state("post_reset7", 16'h0123, 1'b0, 1'b0);
    cyc(1);
    chk_state("post_reset8", 16'h1234, 1'b0, 1'b1);

    // Pause event lands on the terminal-count cycle
    push_n(1);
    cyc(1);
    btn_pause = 1'b1; cyc(6);
    btn_pause = 1'b0; cyc(1);
    chk_state("simul_scroll", 16'h2345, 1'b1, 1'b1);
    cyc(40);
    chk_state("simul_frozen", 16'h2345, 1'b1, 1'b0);

    // Step and pause together while paused: step taken and resumed
    push_n(1);
    btn_pause = 1'b1; btn_step = 1'b1; cyc(6);
    btn_pause = 1'b0; btn_step = 1'b0; cyc(1);
    chk_state("step_resume", 16'h3456, 1'b0, 1'b1);
    push_n(1);
    cyc(8);
    chk_state("step_resume_next", 16'h4567, 1'b0, 1'b1);

    check("sb_drained", 16'(exp_q.size()), 16'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
